// File: rtl/pre_bitstream_gatherer.sv
// Gathers up to two words per lane per beat, compacts them in lane order and
// queues them in a circular FIFO for a one-word-per-cycle consumer.
module pre_bitstream_gatherer #(
  parameter int LANES      = 3,
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                        general_clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*LANES-1:0]          in_flag,
  input  logic [LANES*WORD_WIDTH-1:0] in_word_1,
  input  logic [LANES*WORD_WIDTH-1:0] in_word_2,
  output logic                        out_valid,
  output logic [WORD_WIDTH-1:0]       out_data,
  input  logic                        out_ready,
  output logic [CNT_WIDTH-1:0]        occupancy,
  output logic                        flag_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C    = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] BEAT_WORDS = CNT_WIDTH'(2 * LANES);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_WIDTH-1:0]  occ;
  logic                  err;

  logic                  accept;
  logic                  rd;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic [CNT_WIDTH-1:0]  wr_cnt;
  logic [LANES-1:0]      en_1;
  logic [LANES-1:0]      en_2;
  logic [LANES-1:0]      illegal;
  logic [PTR_W-1:0]      idx_1 [LANES];
  logic [PTR_W-1:0]      idx_2 [LANES];

  // Running prefix sum gives each lane its slot offset from the write pointer;
  // pointer arithmetic truncates to PTR_W so straddling writes wrap naturally.
  always_comb begin
    beat_cnt = '0;
    en_1     = '0;
    en_2     = '0;
    illegal  = '0;
    idx_1    = '{default: '0};
    idx_2    = '{default: '0};
    for (int k = 0; k < LANES; k++) begin
      en_1[k]    = |in_flag[2*k +: 2];
      en_2[k]    = in_flag[2*k+1];
      illegal[k] = &in_flag[2*k +: 2];
      idx_1[k]   = wr_ptr + PTR_W'(beat_cnt);
      idx_2[k]   = idx_1[k] + PTR_W'(1);
      beat_cnt   = beat_cnt + CNT_WIDTH'(en_1[k]) + CNT_WIDTH'(en_2[k]);
    end
  end

  // Readiness looks only at registered occupancy, so a full beat always fits.
  assign in_ready   = (DEPTH_C - occ) >= BEAT_WORDS;
  assign accept     = in_valid & in_ready;
  assign out_valid  = (occ != '0);
  assign rd         = out_valid & out_ready;
  assign wr_cnt     = accept ? beat_cnt : '0;
  assign out_data   = mem[rd_ptr];
  assign occupancy  = occ;
  assign flag_error = err;

  always_ff @(posedge general_clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      err    <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(rd);
      wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
      occ    <= occ + wr_cnt - CNT_WIDTH'(rd);
      if (accept && (|illegal)) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge general_clk) begin
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (en_1[k]) mem[idx_1[k]] <= in_word_1[k*WORD_WIDTH +: WORD_WIDTH];
        if (en_2[k]) mem[idx_2[k]] <= in_word_2[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_pre_bitstream_gatherer.sv
// Bench for pre_bitstream_gatherer: directed scenarios then random traffic,
// all checked against a word-queue reference model.
module tb_pre_bitstream_gatherer;

  localparam int L  = 3;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

  logic              general_clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2*L-1:0]    in_flag;
  logic [L*W-1:0]    in_word_1;
  logic [L*W-1:0]    in_word_2;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_ready;
  logic [CW-1:0]     occupancy;
  logic              flag_error;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] q[$];
  logic         m_ferr = 1'b0;

  pre_bitstream_gatherer #(
    .LANES(L), .WORD_WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)
  ) dut (
    .general_clk(general_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_flag    (in_flag),
    .in_word_1  (in_word_1),
    .in_word_2  (in_word_2),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .flag_error (flag_error)
  );

  always #5 general_clk = ~general_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [L*W-1:0] rand_words();
    logic [L*W-1:0] x;
    for (int k = 0; k < L; k++) x[k*W +: W] = W'($urandom());
    return x;
  endfunction

  task automatic drive(input logic v, input logic [2*L-1:0] f, input logic r, input logic rst);
    in_valid  = v;
    in_flag   = f;
    in_word_1 = rand_words();
    in_word_2 = rand_words();
    out_ready = r;
    reset     = rst;
  endtask

  task automatic check_state();
    chk("occupancy", 32'(occupancy), q.size());
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'((D - q.size()) >= 2 * L));
    chk("flag_error", 32'(flag_error), 32'(m_ferr));
    if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
  endtask

  // One clock: check outputs, predict from the pre-edge inputs, advance model.
  task automatic cyc();
    logic         acc;
    logic         rd;
    logic         bad;
    logic [1:0]   f;
    logic [W-1:0] nw[$];
    check_state();
    acc = in_valid && ((D - q.size()) >= 2 * L);
    rd  = (q.size() != 0) && out_ready;
    bad = 1'b0;
    for (int k = 0; k < L; k++) begin
      f = in_flag[2*k +: 2];
      if (f != 2'd0) nw.push_back(in_word_1[k*W +: W]);
      if (f >= 2'd2) nw.push_back(in_word_2[k*W +: W]);
      if (f == 2'd3) bad = 1'b1;
    end
    @(posedge general_clk);
    #1;
    if (reset) begin
      q.delete();
      m_ferr = 1'b0;
    end else begin
      if (rd) void'(q.pop_front());
      if (acc) begin
        foreach (nw[i]) q.push_back(nw[i]);
        if (bad) m_ferr = 1'b1;
      end
    end
  endtask

  initial begin
    logic [1:0]     f;
    logic [2*L-1:0] fl;

    drive(1'b0, '0, 1'b0, 1'b1);
    cyc();
    cyc();
    drive(1'b0, '0, 1'b1, 1'b0);
    cyc();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);

    // Single mixed beat: lane0 two words, lane1 none, lane2 one word.
    drive(1'b1, 6'b01_00_10, 1'b1, 1'b0);
    in_word_1 = {16'hC1C1, 16'h5555, 16'hA1A1};
    in_word_2 = {16'h7777, 16'h6666, 16'hA2A2};
    cyc();
    chk("mix_occ", 32'(occupancy), 32'd3);
    chk("mix_first_valid", 32'(out_valid), 32'd1);
    chk("mix_word0", 32'(out_data), 32'hA1A1);
    drive(1'b0, '0, 1'b1, 1'b0);
    cyc();
    chk("mix_word1", 32'(out_data), 32'hA2A2);
    cyc();
    chk("mix_word2", 32'(out_data), 32'hC1C1);
    cyc();
    chk("mix_drained", 32'(occupancy), 32'd0);

    // Backpressure: two full beats then a rejected one.
    drive(1'b1, 6'b10_10_10, 1'b0, 1'b0);
    cyc();
    chk("full_occ6", 32'(occupancy), 32'd6);
    drive(1'b1, 6'b10_10_10, 1'b0, 1'b0);
    cyc();
    chk("full_occ12", 32'(occupancy), 32'd12);
    chk("full_not_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 6'b10_10_10, 1'b0, 1'b0);
    cyc();
    chk("full_rejected", 32'(occupancy), 32'd12);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (12) cyc();

    // Wrap: pointers from zero, fill to 14, drain to 2, write 6 across the boundary.
    drive(1'b0, '0, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 6'b10_10_10, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 6'b00_10_10, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 6'b10_00_10, 1'b0, 1'b0);
    cyc();
    chk("wrap_occ14", 32'(occupancy), 32'd14);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (12) cyc();
    chk("wrap_occ2", 32'(occupancy), 32'd2);
    drive(1'b1, 6'b10_10_10, 1'b0, 1'b0);
    cyc();
    chk("wrap_occ8", 32'(occupancy), 32'd8);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (8) cyc();
    chk("wrap_drained", 32'(occupancy), 32'd0);

    // Simultaneous read and six-word write at occupancy 1.
    drive(1'b1, 6'b00_00_01, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 6'b10_10_10, 1'b1, 1'b0);
    cyc();
    chk("rw_occ6", 32'(occupancy), 32'd6);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (6) cyc();

    // Illegal flag on lane 1: both words kept, sticky error.
    drive(1'b1, 6'b00_11_00, 1'b0, 1'b0);
    cyc();
    chk("illegal_err", 32'(flag_error), 32'd1);
    chk("illegal_occ", 32'(occupancy), 32'd2);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) cyc();
    chk("illegal_sticky", 32'(flag_error), 32'd1);

    // Reset mid-stream at occupancy 9, colliding with accept and read.
    drive(1'b1, 6'b10_10_10, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 6'b01_01_01, 1'b0, 1'b0);
    cyc();
    chk("pre_reset_occ9", 32'(occupancy), 32'd9);
    drive(1'b1, 6'b10_10_10, 1'b1, 1'b1);
    cyc();
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_flag_error", 32'(flag_error), 32'd0);

    // Random traffic.
    repeat (400) begin
      fl = '0;
      for (int k = 0; k < L; k++) begin
        f = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 29) == 0) f = 2'd3;
        fl[2*k +: 2] = f;
      end
      drive(1'($urandom_range(0, 1)), fl, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 59) == 0));
      cyc();
    end

    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (D + 2) cyc();
    chk("final_empty", 32'(occupancy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pre_bitstream_gatherer.md
PRE_BITSTREAM_GATHERER -- requirements
Module: pre_bitstream_gatherer

Parameters
REQ-001 LANES, default 3: number of parallel bool/symbol output lanes delivered per encoder cycle (1..8).
REQ-002 WORD_WIDTH, default 16: width of each pre-bitstream word.
REQ-003 DEPTH, default 16: FIFO depth in words; power of two, at least 2*LANES.
REQ-004 CNT_WIDTH, default $clog2(DEPTH)+1: width of the occupancy count.

Interface
REQ-005 general_clk  in  1  clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  lane words and flags are present this cycle.
REQ-008 in_ready  out  1  gatherer can accept a full LANES-wide beat.
REQ-009 in_flag  in  2*LANES  2-bit flag per lane; lane k at bits [2k+1:2k]; 0 = no word, 1 = word_1 only, 2 = word_1 then word_2, 3 = illegal.
REQ-010 in_word_1  in  LANES*WORD_WIDTH  first word per lane; lane k at bits [(k+1)*WORD_WIDTH-1 : k*WORD_WIDTH].
REQ-011 in_word_2  in  LANES*WORD_WIDTH  second word per lane; same packing as in_word_1.
REQ-012 out_valid  out  1  out_data holds a valid word.
REQ-013 out_data  out  WORD_WIDTH  head-of-FIFO word.
REQ-014 out_ready  in  1  downstream consumes out_data when out_valid is also high.
REQ-015 occupancy  out  CNT_WIDTH  words currently stored.
REQ-016 flag_error  out  1  sticky; set on an illegal flag.

Function
REQ-017 A beat SHALL be accepted when in_valid and in_ready are both high.
REQ-018 Inputs with in_valid high and in_ready low SHALL be ignored and not stored.
REQ-019 in_ready SHALL be high iff DEPTH - occupancy >= 2*LANES, computed from registered occupancy only (conservative; same-cycle reads not credited).
REQ-020 Words of an accepted beat SHALL be compacted and written in this order: lane 0 word_1, lane 0 word_2, lane 1 word_1, ... lane LANES-1 word_2. Only words enabled by their flag are written; no gaps are left in the FIFO.
REQ-021 Up to 2*LANES words SHALL be written per cycle; write pointer advances by the number of words written, modulo DEPTH.
REQ-022 Flag value 3 SHALL be treated as 2 (both words written) and SHALL set flag_error on the following edge.
REQ-023 flag_error SHALL stay set until reset.
REQ-024 A read SHALL occur when out_valid and out_ready are both high. The read pointer advances by 1 modulo DEPTH.
REQ-025 out_valid SHALL equal (occupancy != 0). out_data SHALL be the word at the read pointer; its value is don't-care while out_valid is low.
REQ-026 A word written on edge N SHALL be visible on out_data after edge N (one-cycle latency) when the FIFO was empty.
REQ-027 occupancy SHALL update each edge as occupancy + words_written - (read ? 1 : 0).
REQ-028 A simultaneous read and write, including at empty or near-full, SHALL be handled in the same cycle without loss.
REQ-029 An accepted beat with all flags 0 SHALL leave the FIFO unchanged.
REQ-030 Pointers SHALL wrap at DEPTH. Compacted writes straddling the wrap boundary SHALL be split correctly.

Reset
REQ-031 On reset high at a clock edge, the following SHALL be cleared: read pointer, write pointer, occupancy, and flag_error.
REQ-032 After that reset edge: out_valid = 0 and in_ready = 1.
REQ-033 Reset SHALL override any concurrent accept or read in the same cycle; stored words are discarded.
REQ-034 Storage contents need not be reset.

Verification
REQ-035 Defaults, reset, then one beat with flags lane0=2, lane1=0, lane2=1 and words 0xA1A1/0xA2A2, x, 0xC1C1 -> occupancy 3; out_data sequence 0xA1A1, 0xA2A2, 0xC1C1 with out_ready held high; out_valid first high one cycle after accept.
REQ-036 out_ready low, beats with all flags 2 -> occupancy 6 then 12; in_ready goes low at occupancy 12 (16-12 < 6); a further beat is rejected and occupancy stays 12.
REQ-037 Fill to 14 then drain to 2, then accept a 6-word beat -> words wrap through index 15 to 0 and are read back in order.
REQ-038 Simultaneous read and 6-word write at occupancy 1 -> occupancy 6 next cycle; data order is preserved.
REQ-039 Flag 3 on lane 1 -> both lane 1 words stored and flag_error = 1 until reset.
REQ-040 Reset asserted mid-stream with occupancy 9 -> next cycle occupancy 0, out_valid 0, in_ready 1, flag_error 0.
